// File: rtl/peri_led_ctrl.sv
// rtl/peri_led_ctrl.sv - Wishbone LED/debug peripheral: static, blink, PWM or off per channel.
module peri_led_ctrl #(
  parameter int         CHANNELS      = 8,
  parameter int         PRESC_W       = 16,
  parameter logic [7:0] RESET_PATTERN = 8'hDB
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_adr_i,
  input  logic [7:0]          wb_dat_i,
  input  logic                wb_stb_i,
  output logic [7:0]          wb_dat_o,
  output logic                wb_ack_o,
  output logic [CHANNELS-1:0] led_o
);

  // Registers are held at full byte width; masks keep unimplemented bits at zero.
  localparam logic [7:0]  CH_MASK    = 8'((16'd1 << CHANNELS) - 16'd1);
  localparam logic [15:0] MODE_MASK  = 16'((32'd1 << (2 * CHANNELS)) - 32'd1);
  localparam logic [15:0] PRESC_MASK = 16'((32'd1 << PRESC_W) - 32'd1);

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_PWM    = 2'b10;

  logic [7:0]  level;
  logic [15:0] mode;
  logic [7:0]  duty [8];
  logic [7:0]  blink_div;
  logic [15:0] presc;

  logic [15:0] presc_cnt;
  logic [7:0]  pwm_cnt;
  logic [7:0]  blink_cnt;
  logic        blink_phase;

  logic                acc;
  logic                wr;
  logic                tick;
  logic                presc_wr;
  logic                blink_wr;
  logic                duty_sel;
  logic [7:0]          rd_data;
  logic [CHANNELS-1:0] led_next;

  assign acc      = wb_stb_i & ~wb_ack_o;
  assign wr       = acc & wb_we_i;
  assign tick     = (presc_cnt == presc);
  assign presc_wr = wr & ((wb_adr_i == 4'h4) | (wb_adr_i == 4'h5));
  assign blink_wr = wr & (wb_adr_i == 4'h3);
  assign duty_sel = wb_adr_i[3] && (int'(wb_adr_i[2:0]) < CHANNELS);

  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      4'h0: rd_data = level;
      4'h1: rd_data = mode[7:0];
      4'h2: rd_data = mode[15:8];
      4'h3: rd_data = blink_div;
      4'h4: rd_data = presc[7:0];
      4'h5: rd_data = presc[15:8];
      4'h6: rd_data[CHANNELS-1:0] = led_o;
      default: if (duty_sel) rd_data = duty[wb_adr_i[2:0]];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= 8'h00;
      level     <= RESET_PATTERN & CH_MASK;
      mode      <= '0;
      blink_div <= 8'h00;
      presc     <= '0;
      for (int i = 0; i < 8; i++) duty[i] <= 8'h80;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= acc ? rd_data : 8'h00;
      if (wr) begin
        case (wb_adr_i)
          4'h0: level       <= wb_dat_i & CH_MASK;
          4'h1: mode[7:0]   <= wb_dat_i & MODE_MASK[7:0];
          4'h2: mode[15:8]  <= wb_dat_i & MODE_MASK[15:8];
          4'h3: blink_div   <= wb_dat_i;
          4'h4: presc[7:0]  <= wb_dat_i & PRESC_MASK[7:0];
          4'h5: presc[15:8] <= wb_dat_i & PRESC_MASK[15:8];
          default: if (duty_sel) duty[wb_adr_i[2:0]] <= wb_dat_i;
        endcase
      end
    end
  end

  // A register write clearing a counter wins over that counter's tick increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_cnt   <= '0;
      pwm_cnt     <= 8'h00;
      blink_cnt   <= 8'h00;
      blink_phase <= 1'b0;
    end else begin
      if (presc_wr || tick) presc_cnt <= '0;
      else                  presc_cnt <= presc_cnt + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
      if (blink_wr)  blink_cnt <= 8'h00;
      else if (tick) blink_cnt <= (blink_cnt == blink_div) ? 8'h00 : blink_cnt + 8'd1;
      if (tick && (blink_cnt == blink_div)) blink_phase <= ~blink_phase;
    end
  end

  always_comb begin
    led_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode[2*i +: 2])
        MODE_STATIC: led_next[i] = level[i];
        MODE_BLINK:  led_next[i] = level[i] & blink_phase;
        MODE_PWM:    led_next[i] = (pwm_cnt < duty[i]) || (duty[i] == 8'hFF);
        default:     led_next[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) led_o <= RESET_PATTERN[CHANNELS-1:0];
    else         led_o <= led_next;
  end

endmodule

// File: tb/tb_peri_led_ctrl.sv
// tb/tb_peri_led_ctrl.sv - Scoreboard bench for peri_led_ctrl.
module tb_peri_led_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       we    = 1'b0;
  logic       stb   = 1'b0;
  logic [3:0] adr   = 4'h0;
  logic [7:0] dat   = 8'h00;
  logic [7:0] dat_o;
  logic       ack;
  logic [7:0] led;

  int checks = 0;
  int errors = 0;

  // Each entry: {is_read, expected read data}.
  logic [8:0] sb_q [$];
  logic [8:0] mon_e;

  peri_led_ctrl #(.CHANNELS(8), .PRESC_W(12), .RESET_PATTERN(8'hDB)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .wb_we_i (we),
    .wb_adr_i(adr),
    .wb_dat_i(dat),
    .wb_stb_i(stb),
    .wb_dat_o(dat_o),
    .wb_ack_o(ack),
    .led_o   (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack with dat %0h, expected no ack", dat_o);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e[8]) chk("rd_data", {24'h0, dat_o}, {24'h0, mon_e[7:0]});
        end
      end else begin
        chk("dat_idle_zero", {24'h0, dat_o}, 32'h0);
      end
    end
  end

  task automatic bus(input logic w, input logic [3:0] a, input logic [7:0] d, input logic [7:0] exp);
    @(negedge clk);
    we  = w;
    adr = a;
    dat = d;
    stb = 1'b1;
    sb_q.push_back({~w, exp});
    @(negedge clk);
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus(1'b1, a, d, 8'h00);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp);
    bus(1'b0, a, 8'h00, exp);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      c += int'(led[0]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] ackpat;
    logic [7:0] led_k0, led_k1;
    logic       prev;
    int         cnt, cyc, n;

    // Reset state and basic read
    repeat (3) @(negedge clk);
    chk("reset_led", {24'h0, led}, 32'hDB);
    chk("reset_ack", {31'h0, ack}, 32'h0);
    chk("reset_dat", {24'h0, dat_o}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_led", {24'h0, led}, 32'hDB);
    rd(4'h0, 8'hDB);

    // Held write strobe: acked every second cycle
    @(negedge clk);
    we = 1'b1; adr = 4'h0; dat = 8'h5A; stb = 1'b1;
    sb_q.push_back(9'h000);
    sb_q.push_back(9'h000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ackpat[k] = ack;
      if (k == 0) led_k0 = led;
      if (k == 1) led_k1 = led;
    end
    stb = 1'b0; we = 1'b0;
    chk("held_ack_pattern", {28'h0, ackpat}, 32'h5);
    chk("led_before_update", {24'h0, led_k0}, 32'hDB);
    chk("led_after_write", {24'h0, led_k1}, 32'h5A);

    // PWM on channel 0, PRESC=0 so one tick per clock
    wr(4'h1, 8'h02);
    wr(4'h8, 8'h40);
    settle();
    count_high(256, cnt);
    chk("pwm_duty_40", cnt, 64);
    chk("pwm_other_bits", {25'h0, led[7:1]}, 32'h2D);
    wr(4'h8, 8'h00);
    settle();
    count_high(256, cnt);
    chk("pwm_duty_00", cnt, 0);
    wr(4'h8, 8'hFF);
    settle();
    count_high(256, cnt);
    chk("pwm_duty_ff", cnt, 256);

    // Blink: PRESC=3, BLINK_DIV=1 -> toggle every 8 clocks
    wr(4'h0, 8'h5B);
    wr(4'h1, 8'h01);
    wr(4'h4, 8'h03);
    wr(4'h3, 8'h01);
    settle();
    prev = led[0]; cyc = 0; n = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk);
      cyc++;
      if (led[0] !== prev) begin
        if (n > 0) chk("blink_period", cyc, 8);
        n++;
        cyc  = 0;
        prev = led[0];
      end
    end
    if (n < 4) chk("blink_toggles", n, 4);

    // Static, forced off, unused addresses, PRESC masking, STATUS
    wr(4'h1, 8'h00);
    settle();
    chk("static_led", {24'h0, led}, 32'h5B);
    wr(4'h2, 8'h30);
    settle();
    chk("ch6_off", {24'h0, led}, 32'h1B);
    wr(4'h2, 8'h00);
    rd(4'h7, 8'h00);
    rd(4'hF, 8'h80);
    wr(4'h5, 8'hF0);
    rd(4'h5, 8'h00);
    wr(4'h5, 8'hA5);
    rd(4'h5, 8'h05);
    wr(4'h5, 8'h00);
    rd(4'h4, 8'h03);
    wr(4'h6, 8'h00);
    settle();
    chk("status_write_ignored", {24'h0, led}, 32'h5B);
    rd(4'h6, 8'h5B);
    wr(4'h7, 8'hFF);
    rd(4'h7, 8'h00);

    // Asynchronous reset in the middle of PWM and of an access
    wr(4'h1, 8'h02);
    wr(4'h8, 8'h40);
    repeat (10) @(negedge clk);
    @(negedge clk);
    we = 1'b0; adr = 4'h0; stb = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_access_ack", {31'h0, ack}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_led", {24'h0, led}, 32'hDB);
    chk("async_ack", {31'h0, ack}, 32'h0);
    chk("async_dat", {24'h0, dat_o}, 32'h0);
    stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    settle();
    chk("post_reset_led", {24'h0, led}, 32'hDB);
    rd(4'h0, 8'hDB);
    rd(4'h1, 8'h00);
    rd(4'h2, 8'h00);
    rd(4'h3, 8'h00);
    rd(4'h4, 8'h00);
    rd(4'h5, 8'h00);
    rd(4'h8, 8'h80);
    rd(4'h6, 8'hDB);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
